// File: rtl/shared_mem_responder_pkg.sv
// Shared definitions for the shared-memory responder: default widths and the
// responder FSM state encoding.
package shared_mem_responder_pkg;

  localparam int NUM_CORES_DEF = 16;
  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESP    = 2'd2,
    RELEASE = 2'd3
  } state_t;

endpackage

// File: rtl/shared_mem_responder_rr_arbiter.sv
// Round-robin request picker: returns the first eligible core index at or
// after rr_ptr, wrapping past NUM_CORES-1 back to 0.
module rr_arbiter #(
  parameter int NUM_CORES = 16,
  parameter int ID_W      = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic [NUM_CORES-1:0] eligible,
  input  logic [ID_W-1:0]      rr_ptr,
  output logic                 gnt_vld,
  output logic [ID_W-1:0]      gnt_id
);

  int idx;

  // Scan from the farthest rotated position down to rr_ptr so the nearest eligible core wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/shared_mem_responder.sv
// Responder end of the core<->shared-memory load/store handshake. One access
// at a time is served from an internal single-port array; cores are picked
// round-robin and each held request is served exactly once.
module shared_mem_responder
  import shared_mem_responder_pkg::*;
#(
  parameter int NUM_CORES = NUM_CORES_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int LAT       = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_CORES-1:0]        mem_req,
  input  logic [NUM_CORES-1:0]        mem_we,
  input  logic [NUM_CORES*ADDR_W-1:0] addr_flat,
  input  logic [NUM_CORES*DATA_W-1:0] wdata_flat,
  output logic [NUM_CORES-1:0]        val_data,
  output logic [DATA_W-1:0]           mem_dat,
  output logic                        busy
);

  localparam int ID_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [ID_W-1:0]        gnt_id;
  logic                   we_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      wdata_q;
  logic [CNT_W-1:0]       cnt;
  logic [NUM_CORES-1:0]   served;
  logic [NUM_CORES-1:0]   eligible;
  logic [NUM_CORES-1:0]   done_vec;
  logic                   arb_vld;
  logic [ID_W-1:0]        arb_id;
  logic                   complete;
  logic                   mem_wr;
  logic                   grant;

  logic [DATA_W-1:0]      mem [0:(1<<ADDR_W)-1];

  assign eligible = mem_req & ~served;
  assign grant    = (state == IDLE) && arb_vld;
  assign complete = (state == ACCESS) && (cnt == '0);
  // Gating with reset drops a store whose completion edge coincides with reset assertion.
  assign mem_wr   = complete && we_q && !reset;

  rr_arbiter #(
    .NUM_CORES (NUM_CORES),
    .ID_W      (ID_W)
  ) u_arb (
    .eligible (eligible),
    .rr_ptr   (rr_ptr),
    .gnt_vld  (arb_vld),
    .gnt_id   (arb_id)
  );

  // One-hot completion vector for the currently granted core.
  always_comb begin
    done_vec = '0;
    done_vec[gnt_id] = 1'b1;
  end

  // Capture the granted core's address and store data; these are not reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      addr_q  <= addr_flat[arb_id*ADDR_W +: ADDR_W];
      wdata_q <= wdata_flat[arb_id*DATA_W +: DATA_W];
    end
  end

  // Synchronous single-port array write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wr) mem[addr_q] <= wdata_q;
  end

  // Responder FSM: grant, count out the array latency, pulse completion, release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_id   <= '0;
      we_q     <= 1'b0;
      cnt      <= '0;
      served   <= '0;
      val_data <= '0;
      mem_dat  <= '0;
      busy     <= 1'b0;
    end else begin
      // A core must drop its request for a cycle before it becomes eligible again.
      served <= (served | (complete ? done_vec : '0)) & mem_req;
      unique case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt_id <= arb_id;
            we_q   <= mem_we[arb_id];
            cnt    <= CNT_W'(LAT - 1);
            busy   <= 1'b1;
            state  <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            if (!we_q) mem_dat <= mem[addr_q];
            val_data <= done_vec;
            state    <= RESP;
          end
        end
        RESP: begin
          val_data <= '0;
          rr_ptr   <= (gnt_id == ID_W'(NUM_CORES - 1)) ? '0 : gnt_id + 1'b1;
          state    <= RELEASE;
        end
        RELEASE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shared_mem_responder.sv
// Bench for shared_mem_responder: directed scenarios plus randomized request
// batches, with expected completions queued by a transaction-level model and
// checked by an independent monitor.
module tb_shared_mem_responder;

  localparam int N   = 16;
  localparam int AW  = 12;
  localparam int DW  = 8;
  localparam int LAT = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    mem_req;
  logic [N-1:0]    mem_we;
  logic [N*AW-1:0] addr_flat;
  logic [N*DW-1:0] wdata_flat;
  logic [N-1:0]    val_data;
  logic [DW-1:0]   mem_dat;
  logic            busy;

  shared_mem_responder #(
    .NUM_CORES (N),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .LAT       (LAT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .addr_flat  (addr_flat),
    .wdata_flat (wdata_flat),
    .val_data   (val_data),
    .mem_dat    (mem_dat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int        id;
    int        cyc;
    bit        chk;
    logic [7:0] dat;
  } exp_t;

  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  exp_t       sbq[$];
  logic [7:0] ref_mem [4096];
  bit         ref_ok  [4096];
  int         rr_m  = 0;
  int         pulses [N];
  logic [11:0] pool [6] = '{12'h0A5, 12'h7FF, 12'h000, 12'h123, 12'hFFF, 12'h3C0};

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every completion pulse must match the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && val_data != '0) begin
      exp_t e;
      int   id;
      id = -1;
      for (int i = 0; i < N; i++) if (val_data[i]) id = i;
      total++;
      if (!$onehot(val_data)) begin
        bad++;
        $display("FAIL onehot val_data=%h required one bit", val_data);
      end
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_val core=%0d cyc=%0d required no completion", id, cyc);
      end else begin
        e = sbq.pop_front();
        pulses[id]++;
        if (id != e.id || cyc != e.cyc) begin
          bad++;
          $display("FAIL order core=%0d cyc=%0d required core=%0d cyc=%0d", id, cyc, e.id, e.cyc);
        end
        if (e.chk) begin
          total++;
          if (mem_dat !== e.dat) begin
            bad++;
            $display("FAIL load_data core=%0d got=%h required=%h", id, mem_dat, e.dat);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic set_core(input int id, input logic [11:0] a, input logic [7:0] d);
    addr_flat[id*AW +: AW]  = a;
    wdata_flat[id*DW +: DW] = d;
  endtask

  // Issue a batch of simultaneous requests from an idle responder and predict
  // the round-robin service order, data and completion cycles.
  task automatic issue(input logic [N-1:0] mask, input logic [N-1:0] we,
                       input int hold_core, input int drop_core);
    int         order[$];
    int         base;
    int         c0;
    int         id;
    int         budget;
    logic [11:0] a;
    exp_t       e;
    for (int j = 0; j < N; j++) begin
      id = (rr_m + j) % N;
      if (mask[id]) order.push_back(id);
    end
    c0   = cyc;
    base = cyc + 1 + LAT;
    for (int k = 0; k < order.size(); k++) begin
      id    = order[k];
      a     = addr_flat[id*AW +: AW];
      e.id  = id;
      e.cyc = base + k * (LAT + 3);
      if (we[id]) begin
        ref_mem[a] = wdata_flat[id*DW +: DW];
        ref_ok[a]  = 1'b1;
        e.chk      = 1'b0;
        e.dat      = '0;
      end else begin
        e.chk = ref_ok[a];
        e.dat = ref_mem[a];
      end
      sbq.push_back(e);
    end
    if (order.size() > 0) rr_m = (order[order.size()-1] + 1) % N;
    mem_we  = we;
    mem_req = mask;
    budget  = N * (LAT + 3) + 40;
    do begin
      @(negedge clk);
      budget--;
      for (int i = 0; i < N; i++)
        if (mem_req[i] && val_data[i] && i != hold_core) mem_req[i] = 1'b0;
      if (drop_core >= 0 && cyc == c0 + 1) mem_req[drop_core] = 1'b0;
    end while ((sbq.size() != 0 || busy) && budget > 0);
    if (budget <= 0) begin
      total++;
      bad++;
      $display("FAIL batch_timeout pending=%0d busy=%b required pending=0", sbq.size(), busy);
      sbq.delete();
    end
  endtask

  initial begin
    logic [N-1:0] m;
    logic [N-1:0] w;
    int           p7;
    for (int i = 0; i < 4096; i++) begin
      ref_mem[i] = '0;
      ref_ok[i]  = 1'b0;
    end
    for (int i = 0; i < N; i++) pulses[i] = 0;
    reset      = 1'b1;
    mem_req    = '0;
    mem_we     = '0;
    addr_flat  = '0;
    wdata_flat = '0;
    repeat (3) @(negedge clk);
    check("reset_val_data", 32'(val_data), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_mem_dat", 32'(mem_dat), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Three simultaneous requesters from rr_ptr=0 are served 0, 5, 15.
    set_core(0, 12'h010, 8'hA0);
    set_core(5, 12'h020, 8'hA5);
    set_core(15, 12'h030, 8'hAF);
    issue(16'h8021, 16'h8021, -1, -1);
    check("batch_three_busy_released", 32'(busy), 32'h0);

    // Core 3 stores then loads the same address.
    set_core(3, 12'h0A5, 8'h5C);
    issue(16'h0008, 16'h0008, -1, -1);
    @(negedge clk);
    issue(16'h0008, 16'h0000, -1, -1);
    check("st_ld_mem_dat", 32'(mem_dat), 32'h5C);

    // Serve core 13 so the pointer sits at 14, then cores 1 and 15: 15 goes first.
    set_core(13, 12'h013, 8'h13);
    issue(16'h2000, 16'h2000, -1, -1);
    set_core(1, 12'h013, 8'h00);
    set_core(15, 12'h013, 8'h00);
    issue(16'h8002, 16'h0000, -1, -1);
    check("wrap_mem_dat_held", 32'(mem_dat), 32'h13);

    // Core 7 keeps its request up after completion: no second grant until it drops.
    set_core(7, 12'h777, 8'h77);
    p7 = pulses[7];
    issue(16'h0080, 16'h0080, 7, -1);
    repeat (12) @(negedge clk);
    check("held_single_grant", 32'(pulses[7]), 32'(p7 + 1));
    check("held_not_busy", 32'(busy), 32'h0);
    mem_req[7] = 1'b0;
    @(negedge clk);
    issue(16'h0080, 16'h0000, -1, -1);
    check("reraise_served", 32'(pulses[7]), 32'(p7 + 2));

    // Core 9 drops its request mid-access: still completes, not served again.
    set_core(9, 12'h099, 8'h99);
    issue(16'h0200, 16'h0200, -1, 9);
    repeat (10) @(negedge clk);
    check("drop_pulses", 32'(pulses[9]), 32'h1);
    set_core(9, 12'h099, 8'h00);
    issue(16'h0200, 16'h0000, -1, -1);
    check("drop_store_committed", 32'(mem_dat), 32'h99);

    // Reset while core 2's store to 0x7FF is in flight: store is lost.
    set_core(2, 12'h7FF, 8'h11);
    issue(16'h0004, 16'h0004, -1, -1);
    set_core(2, 12'h7FF, 8'hEE);
    mem_we  = 16'h0004;
    mem_req = 16'h0004;
    @(negedge clk);
    check("inflight_busy", 32'(busy), 32'h1);
    reset = 1'b1;
    @(negedge clk);
    mem_req = '0;
    reset   = 1'b0;
    rr_m    = 0;
    check("midreset_val_data", 32'(val_data), 32'h0);
    check("midreset_busy", 32'(busy), 32'h0);
    check("midreset_mem_dat", 32'(mem_dat), 32'h0);
    repeat (6) @(negedge clk);
    issue(16'h0004, 16'h0000, -1, -1);
    check("midreset_store_dropped", 32'(mem_dat), 32'h11);

    // Randomized batches over a small address pool.
    for (int b = 0; b < 40; b++) begin
      m = N'($urandom);
      if (m == '0) m = N'(1) << $urandom_range(0, N - 1);
      w = N'($urandom);
      for (int i = 0; i < N; i++)
        set_core(i, pool[$urandom_range(0, 5)], 8'($urandom));
      issue(m, w, -1, -1);
      @(negedge clk);
    end
    check("final_queue_empty", 32'(sbq.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
